game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level game-flow controller for the scrolling dodge game. It owns the frame timebase and the IDLE/CLEAR/PLAY/OVER state machine. It issues one-cycle enables to the playfield shifter, obstacle spawner and movement logic, and pulses the playfield clear. It also maintains the running score and the session high score, and applies the difficulty ramp by shortening the scroll interval. It sits between the board inputs/collision detector and the playfield datapath.

Parameters:
FRAME_TICKS, 833334, clock cycles per frame (60 Hz at 50 MHz); legal range 2..2^20.
SCROLL_DIV_INIT, 16, frames per row scroll at game start; legal range 1..31.
SCROLL_DIV_MIN, 4, fastest allowed frames per scroll; must be ≥1 and ≤SCROLL_DIV_INIT.
SPEEDUP_ROWS, 256, scrolls between one-step speed-ups.
SPAWN_ROWS, 16, scrolls between spawn requests.
OVER_FRAMES, 120, frames spent in OVER before returning to IDLE.

Ports:
clock  input  1  system clock.
resetn  input  1  synchronous, active-low reset.
start  input  1  start request, active-high level (driven from inverted KEY).
collision  input  1  level from the collision detector; sampled only in PLAY.
frame_tick  output  1  one-cycle pulse per frame; runs in every state.
move_en  output  1  one-cycle pulse per frame, PLAY only.
scroll_en  output  1  one-cycle pulse per playfield row shift.
spawn_en  output  1  one-cycle spawn request.
clear_n  output  1  active-low, one-cycle playfield clear.
state  output  2  0=IDLE, 1=CLEAR, 2=PLAY, 3=OVER.
scroll_div  output  5  current frames per scroll.
score  output  24  rows survived in the current game.
high_score  output  24  best score since reset.

Behaviour:
- Reset values:
  - state=IDLE; all pulse outputs 0; clear_n=1.
  - score=0; high_score=0; scroll_div=SCROLL_DIV_INIT.
  - Frame counter=FRAME_TICKS-1; all internal counters 0; start_q=0.
- Frame timebase:
  - Down-counter free-runs in every state.
  - At 0, the internal tick fires and the counter reloads FRAME_TICKS-1.
  - frame_tick is the registered tick, so it is asserted one cycle after the counter reads 0. Period is exactly FRAME_TICKS cycles.
- Start detect: start_q registers start every cycle; start_rise = start & ~start_q.
- IDLE:
  - No move/scroll/spawn pulses; score holds its last value.
  - On start_rise, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - clear_n=0 for that cycle.
  - Next-edge updates: score←0, scroll_div←SCROLL_DIV_INIT, frame-in-scroll/scroll/spawn/speedup counters←0.
  - Go to PLAY.
- PLAY, on each internal tick (all pulses registered, aligned with frame_tick):
  - move_en=1.
  - The frame-in-scroll counter increments. When it reaches scroll_div-1, it wraps to 0 and:
    - scroll_en=1;
    - score+1, saturating at 24'hFFFFFF;
    - the spawn counter increments; when it reaches SPAWN_ROWS-1 it wraps and spawn_en=1 in the same cycle as scroll_en;
    - the speedup counter increments; when it reaches SPEEDUP_ROWS-1 it wraps and scroll_div decrements by 1, floored at SCROLL_DIV_MIN. The new divisor applies from the next scroll.
- PLAY, collision:
  - Checked every cycle. If collision=1, go to OVER next cycle.
  - Collision has priority over a simultaneous tick: no move/scroll/spawn pulse, no score increment that cycle.
  - start is ignored in PLAY.
- OVER:
  - On the entry cycle, if score > high_score then high_score←score.
  - Count OVER_FRAMES frame ticks, then go to IDLE.
  - start and collision are ignored; no move/scroll/spawn pulses.
- scroll_div changes only in CLEAR and on speed-up events.
- Reset asserted mid-game returns every register to its reset value on the next edge, including high_score.
- Counter widths: sized to hold parameter-1; no wrap beyond the stated terminal counts.

Test Plan:
All scenarios use FRAME_TICKS=4, SCROLL_DIV_INIT=3, SCROLL_DIV_MIN=1, SPEEDUP_ROWS=4, SPAWN_ROWS=2, OVER_FRAMES=2.

1. Release reset, idle 20 cycles -> frame_tick every 4 cycles; state=0; move_en/scroll_en/spawn_en stay 0; score=0.
2. Pulse start high for 5 cycles -> exactly one CLEAR cycle with clear_n=0, then state=2; holding start produces no second CLEAR.
3. Play 12 frames -> move_en on all 12 frame ticks; scroll_en on frames 3, 6, 9, 12; spawn_en on frames 6 and 12; score=4; scroll_div=2 after the 4th scroll.
4. Continue to 3 more speed-ups -> scroll_div goes 2→1 and holds at 1 (SCROLL_DIV_MIN); scroll_en then fires on every frame_tick.
5. Assert collision in the same cycle as a scroll tick with score=7 -> no scroll_en, score stays 7, state=3; high_score=7; after 2 frame ticks state=0. A second game ending at score 5 leaves high_score=7.
6. Assert resetn=0 for 1 cycle mid-PLAY -> all outputs return to reset values on the next edge, high_score=0, state=0.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller: frame timebase, IDLE/CLEAR/PLAY/OVER FSM,
// datapath enables, running score, high score and difficulty ramp.
//
// Ports:
//   clock      in   system clock
//   resetn     in   synchronous active-low reset
//   start      in   start request level; its rising edge starts a game
//   collision  in   collision level, acted on only in PLAY
//   frame_tick out  one-cycle pulse per frame, every state
//   move_en    out  one-cycle pulse per frame in PLAY
//   scroll_en  out  one-cycle pulse per playfield row shift
//   spawn_en   out  one-cycle obstacle spawn request
//   clear_n    out  active-low playfield clear, low for the CLEAR cycle
//   state      out  0=IDLE 1=CLEAR 2=PLAY 3=OVER
//   scroll_div out  current frames per scroll
//   score      out  rows survived in the current game
//   high_score out  best score since reset
module game_sequencer #(
    parameter int FRAME_TICKS     = 833334,
    parameter int SCROLL_DIV_INIT = 16,
    parameter int SCROLL_DIV_MIN  = 4,
    parameter int SPEEDUP_ROWS    = 256,
    parameter int SPAWN_ROWS      = 16,
    parameter int OVER_FRAMES     = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        collision,
    output logic        frame_tick,
    output logic        move_en,
    output logic        scroll_en,
    output logic        spawn_en,
    output logic        clear_n,
    output logic [1:0]  state,
    output logic [4:0]  scroll_div,
    output logic [23:0] score,
    output logic [23:0] high_score
);

    localparam int FW  = (FRAME_TICKS  > 1) ? $clog2(FRAME_TICKS)  : 1;
    localparam int SPW = (SPAWN_ROWS   > 1) ? $clog2(SPAWN_ROWS)   : 1;
    localparam int SUW = (SPEEDUP_ROWS > 1) ? $clog2(SPEEDUP_ROWS) : 1;
    localparam int OVW = (OVER_FRAMES  > 1) ? $clog2(OVER_FRAMES)  : 1;

    localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [SPW-1:0] SPAWN_LAST = SPW'(SPAWN_ROWS - 1);
    localparam logic [SUW-1:0] SPEED_LAST = SUW'(SPEEDUP_ROWS - 1);
    localparam logic [OVW-1:0] OVER_LAST  = OVW'(OVER_FRAMES - 1);
    localparam logic [4:0]     DIV_INIT   = 5'(SCROLL_DIV_INIT);
    localparam logic [4:0]     DIV_MIN    = 5'(SCROLL_DIV_MIN);
    localparam logic [23:0]    SCORE_MAX  = 24'hFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [FW-1:0]    r_frame_cnt;
    logic [4:0]       r_fis_cnt;
    logic [SPW-1:0]   r_spawn_cnt;
    logic [SUW-1:0]   r_speed_cnt;
    logic [OVW-1:0]   r_over_cnt;
    logic             r_start_q;
    logic             r_frame_tick;
    logic             r_move_en;
    logic             r_scroll_en;
    logic             r_spawn_en;
    logic [4:0]       r_scroll_div;
    logic [23:0]      r_score;
    logic [23:0]      r_high;

    logic w_start_rise;
    logic w_tick;
    logic w_play_tick;
    logic w_scroll;
    logic w_spawn;
    logic w_speedup;
    logic w_over_done;

    assign w_start_rise = start & ~r_start_q;
    assign w_tick       = (r_frame_cnt == '0);
    // Collision wins over a coincident tick: the frame is not played.
    assign w_play_tick  = (r_state == S_PLAY) && !collision && w_tick;
    // >= keeps the wrap safe even if the divisor shrank mid-scroll.
    assign w_scroll     = w_play_tick && (r_fis_cnt >= r_scroll_div - 5'd1);
    assign w_spawn      = w_scroll && (r_spawn_cnt == SPAWN_LAST);
    assign w_speedup    = w_scroll && (r_speed_cnt == SPEED_LAST);
    assign w_over_done  = (r_state == S_OVER) && w_tick
                          && (r_over_cnt == OVER_LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_rise) w_next = S_CLEAR;
            S_CLEAR: w_next = S_PLAY;
            S_PLAY:  if (collision) w_next = S_OVER;
            S_OVER:  if (w_over_done) w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_frame_cnt  <= FRAME_LAST;
            r_fis_cnt    <= '0;
            r_spawn_cnt  <= '0;
            r_speed_cnt  <= '0;
            r_over_cnt   <= '0;
            r_start_q    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_move_en    <= 1'b0;
            r_scroll_en  <= 1'b0;
            r_spawn_en   <= 1'b0;
            r_scroll_div <= DIV_INIT;
            r_score      <= '0;
            r_high       <= '0;
        end else begin
            r_frame_cnt  <= w_tick ? FRAME_LAST : r_frame_cnt - 1'b1;
            r_start_q    <= start;
            r_frame_tick <= w_tick;
            r_move_en    <= w_play_tick;
            r_scroll_en  <= w_scroll;
            r_spawn_en   <= w_spawn;

            if (r_state == S_CLEAR) begin
                r_score      <= '0;
                r_scroll_div <= DIV_INIT;
                r_fis_cnt    <= '0;
                r_spawn_cnt  <= '0;
                r_speed_cnt  <= '0;
            end

            if (w_play_tick)
                r_fis_cnt <= w_scroll ? 5'd0 : r_fis_cnt + 5'd1;

            if (w_scroll) begin
                if (r_score != SCORE_MAX) r_score <= r_score + 24'd1;
                r_spawn_cnt <= w_spawn ? '0 : r_spawn_cnt + 1'b1;
                r_speed_cnt <= w_speedup ? '0 : r_speed_cnt + 1'b1;
                if (w_speedup && r_scroll_div > DIV_MIN)
                    r_scroll_div <= r_scroll_div - 5'd1;
            end

            // Score is frozen in OVER, so comparing every cycle
            // behaves the same as comparing only on entry.
            if (r_state == S_OVER && r_score > r_high)
                r_high <= r_score;

            if (r_state == S_OVER && w_tick)
                r_over_cnt <= w_over_done ? '0 : r_over_cnt + 1'b1;
        end
    end

    assign frame_tick = r_frame_tick;
    assign move_en    = r_move_en;
    assign scroll_en  = r_scroll_en;
    assign spawn_en   = r_spawn_en;
    assign clear_n    = (r_state != S_CLEAR);
    assign state      = r_state;
    assign scroll_div = r_scroll_div;
    assign score      = r_score;
    assign high_score = r_high;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a frame scoreboard.
// Expected per-frame pulses/score/divisor are queued at game start.
module tb_game_sequencer;

    localparam int FT  = 4;
    localparam int DVI = 3;
    localparam int DVM = 1;
    localparam int SUR = 4;
    localparam int SPR = 2;
    localparam int OVF = 2;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        collision;
    logic        frame_tick;
    logic        move_en;
    logic        scroll_en;
    logic        spawn_en;
    logic        clear_n;
    logic [1:0]  state;
    logic [4:0]  scroll_div;
    logic [23:0] score;
    logic [23:0] high_score;

    game_sequencer #(
        .FRAME_TICKS(FT),
        .SCROLL_DIV_INIT(DVI),
        .SCROLL_DIV_MIN(DVM),
        .SPEEDUP_ROWS(SUR),
        .SPAWN_ROWS(SPR),
        .OVER_FRAMES(OVF)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .collision(collision),
        .frame_tick(frame_tick),
        .move_en(move_en),
        .scroll_en(scroll_en),
        .spawn_en(spawn_en),
        .clear_n(clear_n),
        .state(state),
        .scroll_div(scroll_div),
        .score(score),
        .high_score(high_score)
    );

    typedef struct packed {
        logic        mv;
        logic        sc;
        logic        sp;
        logic [23:0] score;
        logic [4:0]  div;
    } exp_t;

    exp_t sb[$];

    int n_pass = 0;
    int n_chk  = 0;

    int          m_fis;
    int          m_sp;
    int          m_su;
    int          m_div;
    logic [23:0] m_score;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        exp_t e;
        @(negedge clock);
        if (frame_tick === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("frame", {move_en, scroll_en, spawn_en, score, scroll_div}, e);
        end else begin
            chk("idle_pulses", {29'd0, move_en, scroll_en, spawn_en}, 32'd0);
        end
    endtask

    task automatic model_new_game();
        m_fis   = 0;
        m_sp    = 0;
        m_su    = 0;
        m_div   = DVI;
        m_score = '0;
    endtask

    task automatic push_frames(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.mv = 1'b1;
            if (m_fis == m_div - 1) begin
                m_fis = 0;
                e.sc = 1'b1;
                if (m_score != 24'hFFFFFF) m_score = m_score + 24'd1;
                if (m_sp == SPR - 1) begin
                    m_sp = 0;
                    e.sp = 1'b1;
                end else m_sp++;
                if (m_su == SUR - 1) begin
                    m_su = 0;
                    if (m_div > DVM) m_div--;
                end else m_su++;
            end else m_fis++;
            e.score = m_score;
            e.div   = 5'(m_div);
            sb.push_back(e);
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            cyc();
            k++;
        end while (frame_tick !== 1'b1 && k < 4 * FT);
        chk("tick_wait", 32'(frame_tick), 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            cyc();
            k++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic start_game(input int frames);
        wait_tick();
        model_new_game();
        push_frames(frames);
        start = 1'b1;
        cyc();
        chk("clear_state", 32'(state), 32'd1);
        chk("clear_n_low", 32'(clear_n), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("play_state", 32'(state), 32'd2);
            chk("clear_n_high", 32'(clear_n), 32'd1);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        int n = 0;
        while (state !== 2'd0 && k < 6 * FT * OVF) begin
            cyc();
            k++;
            if (frame_tick === 1'b1) n++;
        end
        chk("over_to_idle", 32'(state), 32'd0);
        chk("over_ticks", 32'(n), 32'(OVF));
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        collision = 1'b0;
        cyc();
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_clear_n", 32'(clear_n), 32'd1);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_high", 32'(high_score), 32'd0);
        chk("rst_div", 32'(scroll_div), 32'(DVI));
        chk("rst_tick", 32'(frame_tick), 32'd0);
        resetn = 1'b1;

        // Idle: tick every FT cycles, first one FT cycles after release.
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("idle_tick", 32'(frame_tick), 32'((i % FT) == 0));
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_score", 32'(score), 32'd0);
        end

        // Game B: reach score 7, collide on the 8th scroll's tick.
        start_game(19);
        drain();
        cyc();
        cyc();
        cyc();
        collision = 1'b1;
        cyc();
        chk("b_over_state", 32'(state), 32'd3);
        chk("b_score_held", 32'(score), 32'd7);
        collision = 1'b0;
        cyc();
        chk("b_high", 32'(high_score), 32'd7);
        wait_idle();

        // Game C: ends at score 5, high score must stay 7.
        start_game(14);
        drain();
        collision = 1'b1;
        cyc();
        chk("c_over_state", 32'(state), 32'd3);
        chk("c_score", 32'(score), 32'd5);
        collision = 1'b0;
        cyc();
        chk("c_high_kept", 32'(high_score), 32'd7);
        wait_idle();
        chk("c_high_idle", 32'(high_score), 32'd7);

        // Game A: 28 frames covers the full ramp down to and at the floor.
        start_game(28);
        drain();
        chk("a_div_floor", 32'(scroll_div), 32'(DVM));
        chk("a_score", 32'(score), 32'd16);

        // Reset mid-PLAY.
        resetn = 1'b0;
        cyc();
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_clear_n", 32'(clear_n), 32'd1);
        chk("mid_rst_score", 32'(score), 32'd0);
        chk("mid_rst_high", 32'(high_score), 32'd0);
        chk("mid_rst_div", 32'(scroll_div), 32'(DVI));
        chk("mid_rst_tick", 32'(frame_tick), 32'd0);
        resetn = 1'b1;
        for (int i = 1; i <= FT; i++) begin
            cyc();
            chk("post_rst_tick", 32'(frame_tick), 32'(i == FT));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
